// File: rtl/adder_pkg.sv
// Shared constants and FSM state type for the chunked wide adder and the
// register-file write path that consumes its results.
package adder_pkg;

  localparam int ADDER_SIZE   = 4;
  localparam int ADDER_CHUNKS = 4;
  localparam int ADDER_WIDTH  = ADDER_SIZE * ADDER_CHUNKS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/chunked_wide_adder_if.sv
// Operand-in / result-out handshake bundle of the chunked wide adder.
interface chunked_wide_adder_if #(
  parameter int WIDTH = adder_pkg::ADDER_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/slice_adder.sv
// Combinational SIZE-bit ripple-carry adder built from full-adder cells.
module slice_adder #(
  parameter int SIZE = adder_pkg::ADDER_SIZE
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] s,
  output logic            cout
);

  logic [SIZE:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[SIZE];

endmodule

// File: rtl/chunked_wide_adder.sv
// Multi-cycle wide adder: one SIZE-bit slice reused CHUNKS times, LSB chunk
// first, with carry held in a register between chunks.
module chunked_wide_adder
  import adder_pkg::*;
#(
  parameter int SIZE   = ADDER_SIZE,
  parameter int CHUNKS = ADDER_CHUNKS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_wide_adder_if.slave  bus
);

  localparam int WIDTH = SIZE * CHUNKS;
  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [SIZE-1:0]    slice_s;
  logic               slice_co;

  slice_adder #(.SIZE(SIZE)) u_slice (
    .a    (a_sh_q[SIZE-1:0]),
    .b    (b_sh_q[SIZE-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SIZE*int'(cnt_q) +: SIZE] = slice_s;
        carry_d = slice_co;
        a_sh_d  = a_sh_q >> SIZE;
        b_sh_d  = b_sh_q >> SIZE;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          cout_d  = slice_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs decode from state alone: no comb path from in_valid/out_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_chunked_wide_adder.sv
// Directed-vector bench for chunked_wide_adder (SIZE=4, CHUNKS=4, WIDTH=16).
module tb_chunked_wide_adder;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  chunked_wide_adder_if #(.WIDTH(WIDTH)) bus ();

  chunked_wide_adder #(.SIZE(4), .CHUNKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept one operation, wait for the result, stall `stall` cycles, then take it.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_sum, input logic exp_cout,
                       input int stall, input bit toggle);
    int lat;
    logic [15:0] s0;
    logic        c0;
    lat = 0;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (toggle) begin
        bus.in_valid = i[0];
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
      end
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'd4);
    check({tag, ".sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, ".cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    s0 = bus.sum;
    c0 = bus.cout;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".hold_sum"}, 32'(bus.sum), 32'(exp_sum));
      check({tag, ".hold_cout"}, 32'(bus.cout), 32'(c0 & exp_cout | (c0 ^ c0)));
      if (bus.sum !== s0) check({tag, ".hold_drift"}, 32'(bus.sum), 32'(s0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bit seen_valid;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.sum", 32'(bus.sum), 32'h0000);
    check("rst.cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle.in_ready", 32'(bus.in_ready), 32'd1);
    check("idle.out_valid", 32'(bus.out_valid), 32'd0);

    do_op("basic",  16'h1234, 16'h4321, 16'h5555, 1'b0, 0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0, 1'b0);
    do_op("stall",  16'h8F0F, 16'h80F1, 16'h1000, 1'b1, 5, 1'b0);
    do_op("toggle", 16'h00FF, 16'h0F01, 16'h1000, 1'b0, 0, 1'b1);
    do_op("zero",   16'h0000, 16'h0000, 16'h0000, 1'b0, 1, 1'b0);

    // Abort at the second RUN cycle: reset must clear outputs without an edge.
    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", 32'(bus.out_valid), 32'd0);
    check("abort.in_ready", 32'(bus.in_ready), 32'd1);
    check("abort.sum", 32'(bus.sum), 32'h0000);
    check("abort.cout", 32'(bus.cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("abort.no_result", 32'(seen_valid), 32'd0);
    check("abort.idle_ready", 32'(bus.in_ready), 32'd1);

    do_op("after_abort", 16'h7FFF, 16'h8001, 16'h0000, 1'b1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
